booth_operand_feeder: RTL

Upstream operand sequencer for the 16-bit signed Booth multiplier. It buffers multiplicand/multiplier pairs from a valid/ready producer in a small FIFO. For each pair it issues a one-cycle `start` to the multiplier controller, then drives M and Q onto the multiplier's shared 16-bit `data_in` bus in the exact cycles the controller loads them. It waits for the multiplier's `done` before issuing the next pair.

---
 rtl/booth_operand_feeder.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/booth_operand_feeder.sv
// Operand FIFO and start/M/Q load sequencer for the 16-bit Booth multiplier.
// Optional WAIT timeout with sticky abort flag: define BOOTH_FEED_TIMEOUT_EN.
module booth_operand_feeder #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [15:0]              in_m,
    input  logic [15:0]              in_q,
    output logic                     mul_start,
    output logic [15:0]              mul_data,
    input  logic                     mul_done,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     timeout_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_LDM   = 3'd2;
    localparam logic [2:0] S_LDQ   = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;

    logic [2:0]    state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level;
    logic [15:0]   mem_m [DEPTH];
    logic [15:0]   mem_q [DEPTH];
    logic [15:0]   hm;
    logic [15:0]   hq;
    logic          done_d;
    logic          push;
    logic          pop;
    logic          done_rise;

    assign in_ready   = (level != FULL_LEVEL);
    assign push       = in_valid && in_ready;
    assign pop        = (state == S_START);
    assign done_rise  = mul_done && !done_d;
    assign fifo_level = level;
    assign busy       = (state != S_IDLE);
    assign mul_start  = (state == S_START);

    always_comb begin
        mul_data = '0;
        if (state == S_LDM)
            mul_data = hm;
        else if (state == S_LDQ)
            mul_data = hq;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_m[wr_ptr] <= in_m;
            mem_q[wr_ptr] <= in_q;
        end
    end

    // A full FIFO refuses the push even when START pops in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

`ifdef BOOTH_FEED_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] tmo_cnt;
    logic          err;
    assign timeout_err = err;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign timeout_err    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            rd_ptr <= '0;
            hm     <= '0;
            hq     <= '0;
            done_d <= 1'b0;
`ifdef BOOTH_FEED_TIMEOUT_EN
            tmo_cnt <= '0;
            err     <= 1'b0;
`endif
        end else begin
            done_d <= mul_done;
            case (state)
                S_IDLE: begin
                    if (level != '0)
                        state <= S_START;
                end
                S_START: begin
                    hm     <= mem_m[rd_ptr];
                    hq     <= mem_q[rd_ptr];
                    rd_ptr <= rd_ptr + 1'b1;
                    state  <= S_LDM;
                end
                S_LDM: state <= S_LDQ;
                S_LDQ: begin
                    state <= S_WAIT;
`ifdef BOOTH_FEED_TIMEOUT_EN
                    tmo_cnt <= CW'(TIMEOUT);
`endif
                end
                S_WAIT: begin
                    // A done level carried in from before WAIT has done_d set, so only a fresh rise counts.
                    if (done_rise)
                        state <= S_IDLE;
`ifdef BOOTH_FEED_TIMEOUT_EN
                    else if (tmo_cnt <= CW'(1)) begin
                        state <= S_IDLE;
                        err   <= 1'b1;
                    end else
                        tmo_cnt <= tmo_cnt - 1'b1;
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
